// File: rtl/spi_reg_sequencer.sv
// SPI-clock-domain frame sequencer: command decode, register strobes, MISO serialiser.
// Optional build macro SPI_SEQ_BURST_EN enables unlimited auto-increment bursts.
module spi_reg_sequencer #(
  parameter logic [6:0] ADDR_LIMIT = 7'h3F,
  parameter logic [7:0] STATUS_ERR = 8'hFF
) (
  input  logic       w_SPI_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  input  logic [7:0] i_Reg_Rd_Data,
  input  logic [7:0] i_Status,
  output logic       o_MISO_Bit,
  output logic [6:0] o_Reg_Addr,
  output logic       o_Reg_Wr_En,
  output logic [7:0] o_Reg_Wr_Data,
  output logic       o_Reg_Rd_En,
  output logic       o_Busy,
  output logic       o_Frame_Err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RD_DUMMY, S_RD, S_WR, S_ERR, S_DONE
  } state_t;

  state_t     r_State, w_State_Nxt;
  logic [2:0] r_Cnt;
  logic [7:0] r_Tx_Sr, r_Rx_Sr, w_Tx_Nxt, w_Byte;
  logic [6:0] r_Addr, w_Addr_Nxt, w_Addr_Inc;
  logic       r_Frame_Err, w_Err_Nxt, w_Close, w_Frame_Rst_n;

  // Frame state is cleared by reset or by chip select going high.
  assign w_Frame_Rst_n = i_Rst_L & ~i_SPI_CS_n;
  assign w_Byte        = {r_Rx_Sr[6:0], i_SPI_MOSI};
  assign w_Close       = (r_Cnt == 3'd7);
  assign w_Addr_Inc    = (r_Addr == ADDR_LIMIT) ? 7'd0 : r_Addr + 7'd1;

  assign o_Reg_Addr    = r_Addr;
  assign o_Frame_Err   = r_Frame_Err;
  assign o_Reg_Wr_Data = w_Byte;
  assign o_Busy        = (r_State != S_IDLE);
  assign o_MISO_Bit    = (r_State != S_IDLE) & r_Tx_Sr[7];

  // Reads run one register ahead: the load at each close fetches the byte
  // sent next, so the address advances at the dummy close as well.
  always_comb begin
    w_State_Nxt = r_State;
    w_Tx_Nxt    = {r_Tx_Sr[6:0], 1'b0};
    w_Addr_Nxt  = r_Addr;
    w_Err_Nxt   = r_Frame_Err;
    o_Reg_Wr_En = 1'b0;
    o_Reg_Rd_En = 1'b0;
    case (r_State)
      S_IDLE: w_State_Nxt = S_CMD;
      S_CMD: begin
        if (w_Close) begin
          if (w_Byte[6:0] > ADDR_LIMIT) begin
            w_State_Nxt = S_ERR;
            w_Tx_Nxt    = STATUS_ERR;
            w_Err_Nxt   = 1'b1;
          end else begin
            w_Addr_Nxt  = w_Byte[6:0];
            w_Err_Nxt   = 1'b0;
            w_Tx_Nxt    = i_Status;
            w_State_Nxt = w_Byte[7] ? S_RD_DUMMY : S_WR;
          end
        end
      end
      S_RD_DUMMY: begin
        if (w_Close) begin
          o_Reg_Rd_En = 1'b1;
          w_Tx_Nxt    = i_Reg_Rd_Data;
          w_Addr_Nxt  = w_Addr_Inc;
          w_State_Nxt = S_RD;
        end
      end
      S_RD: begin
        if (w_Close) begin
`ifdef SPI_SEQ_BURST_EN
          o_Reg_Rd_En = 1'b1;
          w_Tx_Nxt    = i_Reg_Rd_Data;
          w_Addr_Nxt  = w_Addr_Inc;
`else
          w_Tx_Nxt    = 8'h00;
          w_State_Nxt = S_DONE;
`endif
        end
      end
      S_WR: begin
        if (w_Close) begin
          o_Reg_Wr_En = 1'b1;
          w_Addr_Nxt  = w_Addr_Inc;
`ifndef SPI_SEQ_BURST_EN
          w_Tx_Nxt    = 8'h00;
          w_State_Nxt = S_DONE;
`endif
        end
      end
      S_ERR: begin
        w_Err_Nxt = 1'b1;
        if (w_Close) w_Tx_Nxt = STATUS_ERR;
      end
      S_DONE:  w_Tx_Nxt = 8'h00;
      default: w_State_Nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_SPI_Clk or negedge w_Frame_Rst_n) begin
    if (!w_Frame_Rst_n) begin
      r_State <= S_IDLE;
      r_Cnt   <= 3'd0;
      r_Tx_Sr <= 8'h00;
      r_Rx_Sr <= 8'h00;
    end else begin
      r_State <= w_State_Nxt;
      r_Cnt   <= r_Cnt + 3'd1;
      r_Tx_Sr <= w_Tx_Nxt;
      r_Rx_Sr <= w_Byte;
    end
  end

  // Address and error flag persist across frames.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Addr      <= 7'd0;
      r_Frame_Err <= 1'b0;
    end else begin
      r_Addr      <= w_Addr_Nxt;
      r_Frame_Err <= w_Err_Nxt;
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer: frames driven on negedge, outputs sampled #1 later.
module tb_spi_reg_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0] rd_data, status = 8'h81;
  logic       miso, wr_en, rd_en, busy, ferr;
  logic [6:0] addr;
  logic [7:0] wr_data;
  logic [7:0] bank [0:127];
  logic [7:0] tx_b [4];
  logic [7:0] rx_b [4];
  logic [6:0] wr_a_q[$];
  logic [7:0] wr_d_q[$];
  logic [6:0] rd_a_q[$];
  int n_vec = 0, n_err = 0;

  spi_reg_sequencer dut (
    .w_SPI_Clk(clk), .i_Rst_L(rst_n), .i_SPI_CS_n(cs_n), .i_SPI_MOSI(mosi),
    .i_Reg_Rd_Data(rd_data), .i_Status(status), .o_MISO_Bit(miso),
    .o_Reg_Addr(addr), .o_Reg_Wr_En(wr_en), .o_Reg_Wr_Data(wr_data),
    .o_Reg_Rd_En(rd_en), .o_Busy(busy), .o_Frame_Err(ferr)
  );

  always #5 clk = ~clk;
  assign rd_data = bank[addr];

  always @(posedge clk) begin
    if (wr_en) begin
      wr_a_q.push_back(addr);
      wr_d_q.push_back(wr_data);
    end
    if (rd_en) rd_a_q.push_back(addr);
  end

  task automatic clear_logs();
    wr_a_q.delete(); wr_d_q.delete(); rd_a_q.delete();
  endtask

  task automatic cs_low();
    @(posedge clk); #2 cs_n = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] so);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); mosi = b[i];
      #1 so[i] = miso;
    end
  endtask

  task automatic frame(input int n);
    clear_logs();
    cs_low();
    for (int k = 0; k < n; k++) send_byte(tx_b[k], rx_b[k]);
    @(negedge clk); cs_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got %b want 0", miso); end
    n_vec++; if (addr !== 7'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", addr); end
    n_vec++; if ({wr_en, rd_en} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got %b want 00", {wr_en, rd_en}); end
    n_vec++; if ({busy, ferr} !== 2'b00) begin n_err++; $display("FAIL reset_busy_err got %b want 00", {busy, ferr}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write();
    tx_b = '{8'h05, 8'hA7, 8'h00, 8'h00};
    frame(2);
    n_vec++; if (wr_a_q.size() !== 1) begin n_err++; $display("FAIL wr_count got %0d want 1", wr_a_q.size()); end
    else begin
      n_vec++; if (wr_a_q[0] !== 7'h05) begin n_err++; $display("FAIL wr_addr got %h want 05", wr_a_q[0]); end
      n_vec++; if (wr_d_q[0] !== 8'hA7) begin n_err++; $display("FAIL wr_data got %h want a7", wr_d_q[0]); end
    end
    n_vec++; if (addr !== 7'h06) begin n_err++; $display("FAIL wr_addr_after got %h want 06", addr); end
    n_vec++; if (rd_a_q.size() !== 0) begin n_err++; $display("FAIL wr_no_rd got %0d want 0", rd_a_q.size()); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after got %b want 0", busy); end
  endtask

  task automatic test_read();
    bank[7'h10] = 8'h3C; bank[7'h11] = 8'h6B;
    tx_b = '{8'h90, 8'h00, 8'h00, 8'h00};
    frame(3);
    n_vec++; if (rx_b[0] !== 8'h00) begin n_err++; $display("FAIL rd_miso_cmd got %h want 00", rx_b[0]); end
    n_vec++; if (rx_b[1] !== 8'h81) begin n_err++; $display("FAIL rd_miso_status got %h want 81", rx_b[1]); end
    n_vec++; if (rx_b[2] !== 8'h3C) begin n_err++; $display("FAIL rd_miso_data got %h want 3c", rx_b[2]); end
`ifdef SPI_SEQ_BURST_EN
    n_vec++; if (rd_a_q.size() !== 2) begin n_err++; $display("FAIL rd_count got %0d want 2", rd_a_q.size()); end
`else
    n_vec++; if (rd_a_q.size() !== 1) begin n_err++; $display("FAIL rd_count got %0d want 1", rd_a_q.size()); end
`endif
    else begin
      n_vec++; if (rd_a_q[0] !== 7'h10) begin n_err++; $display("FAIL rd_addr got %h want 10", rd_a_q[0]); end
    end
    n_vec++; if (wr_a_q.size() !== 0) begin n_err++; $display("FAIL rd_no_wr got %0d want 0", wr_a_q.size()); end
  endtask

  task automatic test_burst_boundary();
    tx_b = '{8'h3E, 8'h11, 8'h22, 8'h33};
    frame(4);
`ifdef SPI_SEQ_BURST_EN
    n_vec++; if (wr_a_q.size() !== 3) begin n_err++; $display("FAIL burst_count got %0d want 3", wr_a_q.size()); end
    else begin
      n_vec++; if ({wr_a_q[0], wr_a_q[1], wr_a_q[2]} !== {7'h3E, 7'h3F, 7'h00})
        begin n_err++; $display("FAIL burst_addrs got %h %h %h want 3e 3f 00", wr_a_q[0], wr_a_q[1], wr_a_q[2]); end
      n_vec++; if ({wr_d_q[0], wr_d_q[1], wr_d_q[2]} !== 24'h112233)
        begin n_err++; $display("FAIL burst_data got %h %h %h want 11 22 33", wr_d_q[0], wr_d_q[1], wr_d_q[2]); end
    end
    n_vec++; if (addr !== 7'h01) begin n_err++; $display("FAIL burst_addr_after got %h want 01", addr); end
`else
    n_vec++; if (wr_a_q.size() !== 1) begin n_err++; $display("FAIL single_count got %0d want 1", wr_a_q.size()); end
    else begin
      n_vec++; if ({wr_a_q[0], wr_d_q[0]} !== {7'h3E, 8'h11})
        begin n_err++; $display("FAIL single_wr got %h/%h want 3e/11", wr_a_q[0], wr_d_q[0]); end
    end
    n_vec++; if (addr !== 7'h3F) begin n_err++; $display("FAIL single_addr_after got %h want 3f", addr); end
`endif
    n_vec++; if (rx_b[3] !== 8'h00) begin n_err++; $display("FAIL burst_miso_tail got %h want 00", rx_b[3]); end
    n_vec++; if (ferr !== 1'b0) begin n_err++; $display("FAIL burst_no_err got %b want 0", ferr); end
    // single write at the limit wraps the address to zero
    tx_b = '{8'h3F, 8'h5A, 8'h00, 8'h00};
    frame(2);
    n_vec++; if (wr_a_q.size() !== 1) begin n_err++; $display("FAIL wrap_count got %0d want 1", wr_a_q.size()); end
    else begin
      n_vec++; if ({wr_a_q[0], wr_d_q[0]} !== {7'h3F, 8'h5A})
        begin n_err++; $display("FAIL wrap_wr got %h/%h want 3f/5a", wr_a_q[0], wr_d_q[0]); end
    end
    n_vec++; if (addr !== 7'h00) begin n_err++; $display("FAIL wrap_addr_after got %h want 00", addr); end
  endtask

  task automatic test_error();
    tx_b = '{8'h50, 8'h00, 8'h00, 8'h00};
    frame(3);
    n_vec++; if ({rx_b[0], rx_b[1], rx_b[2]} !== 24'h00FFFF)
      begin n_err++; $display("FAIL err_miso got %h %h %h want 00 ff ff", rx_b[0], rx_b[1], rx_b[2]); end
    n_vec++; if (wr_a_q.size() + rd_a_q.size() !== 0)
      begin n_err++; $display("FAIL err_strobes got %0d want 0", wr_a_q.size() + rd_a_q.size()); end
    n_vec++; if (ferr !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b want 1", ferr); end
    n_vec++; if (addr !== 7'h00) begin n_err++; $display("FAIL err_addr_hold got %h want 00", addr); end
    tx_b = '{8'h01, 8'h99, 8'h00, 8'h00};
    frame(2);
    n_vec++; if (ferr !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", ferr); end
    n_vec++; if (wr_a_q.size() !== 1 || wr_a_q[0] !== 7'h01 || wr_d_q[0] !== 8'h99)
      begin n_err++; $display("FAIL err_next_wr got count %0d want 1 write 01/99", wr_a_q.size()); end
  endtask

  task automatic test_partial();
    logic [7:0] s;
    logic [7:0] b;
    // partial first data byte: nothing committed
    clear_logs(); cs_low();
    send_byte(8'h20, s);
    b = 8'h55;
    for (int i = 7; i >= 4; i--) begin @(negedge clk); mosi = b[i]; end
    @(posedge clk); #2 cs_n = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL part1_busy got %b want 0", busy); end
    n_vec++; if (wr_a_q.size() !== 0) begin n_err++; $display("FAIL part1_wr got %0d want 0", wr_a_q.size()); end
    n_vec++; if (addr !== 7'h20) begin n_err++; $display("FAIL part1_addr got %h want 20", addr); end
    // partial second data byte: exactly one write
    clear_logs(); cs_low();
    send_byte(8'h21, s);
    send_byte(8'h44, s);
    for (int i = 7; i >= 4; i--) begin @(negedge clk); mosi = b[i]; end
    @(posedge clk); #2 cs_n = 1'b1;
    #1;
    n_vec++; if ({busy, wr_en} !== 2'b00) begin n_err++; $display("FAIL part2_idle got %b want 00", {busy, wr_en}); end
    n_vec++; if (wr_a_q.size() !== 1 || wr_a_q[0] !== 7'h21 || wr_d_q[0] !== 8'h44)
      begin n_err++; $display("FAIL part2_wr got count %0d want 1 write 21/44", wr_a_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] s;
    bank[7'h10] = 8'h3C;
    clear_logs(); cs_low();
    send_byte(8'h90, s);
    @(negedge clk); mosi = 1'b0;
    #1;
    n_vec++; if ({miso, addr} !== {1'b1, 7'h10}) begin n_err++; $display("FAIL rst_pre got %b/%h want 1/10", miso, addr); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({miso, wr_en, rd_en, busy, ferr} !== 5'b0)
      begin n_err++; $display("FAIL rst_mid_outs got %b want 00000", {miso, wr_en, rd_en, busy, ferr}); end
    n_vec++; if (addr !== 7'h00) begin n_err++; $display("FAIL rst_mid_addr got %h want 00", addr); end
    cs_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    // reset during an error frame clears the sticky flag
    cs_low();
    send_byte(8'h50, s);
    @(posedge clk); #2;
    n_vec++; if (ferr !== 1'b1) begin n_err++; $display("FAIL rst_err_pre got %b want 1", ferr); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({ferr, miso, busy} !== 3'b000) begin n_err++; $display("FAIL rst_err_clear got %b want 000", {ferr, miso, busy}); end
    cs_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) bank[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_burst_boundary();
    test_error();
    test_partial();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_sequencer.md
# spi_reg_sequencer

SPI-clock-domain frame sequencer that sits behind the SPI slave pins and turns each chip-select frame into register-bank accesses.
- Decodes a command byte, then drives one write strobe or read strobe per data byte, with address auto-increment.
- Serialises read data and status back on MISO.
- Runs entirely on the SPI clock, so register writes commit on the last bit edge even when the master stops clocking immediately after.

## Interface
Parameters:
- ADDR_LIMIT, 7'h3F: highest valid register address. Command addresses above it are errors; auto-increment wraps from ADDR_LIMIT to 0.
- STATUS_ERR, 8'hFF: byte driven on MISO while in ERR.

Ports:
- w_SPI_Clk  in  1  SPI clock, polarity/phase already corrected; all logic on posedge.
- i_Rst_L  in  1  Reset, asynchronous, active-low.
- i_SPI_CS_n  in  1  Chip select, active-low. High asynchronously forces frame state to IDLE.
- i_SPI_MOSI  in  1  Serial data in, MSb first.
- i_Reg_Rd_Data  in  8  Combinational read data for o_Reg_Addr; zero latency.
- i_Status  in  8  Status byte returned during the dummy byte of a read.
- o_MISO_Bit  out  1  Serial data out; equals tx_sr[7]; 0 in IDLE.
- o_Reg_Addr  out  7  Registered register address.
- o_Reg_Wr_En  out  1  Combinational; high during 8th bit of a write data byte.
- o_Reg_Wr_Data  out  8  Combinational {rx_sr[6:0], i_SPI_MOSI}; valid while o_Reg_Wr_En is high.
- o_Reg_Rd_En  out  1  Combinational read strobe, for clear-on-read; high during 8th bit of each byte that loads read data.
- o_Busy  out  1  State != IDLE.
- o_Frame_Err  out  1  Sticky error flag.

## Operation
- Command byte: {rw, addr[6:0]}. rw=1 is read, rw=0 is write.
- Bit counter: 3 bits, increments each edge, wraps 7→0. Byte closes on the edge where count==7.
- States:
  - IDLE: async entry on reset or CS high; first edge goes to CMD.
  - CMD: shifts 8 bits. At the close edge:
    - addr > ADDR_LIMIT: go to ERR, tx_sr<=STATUS_ERR.
    - Else latch o_Reg_Addr<=addr, clear o_Frame_Err, tx_sr<=i_Status.
    - Then go to RD_DUMMY (rw=1) or WR (rw=0).
  - RD_DUMMY: MISO shifts i_Status. At close: tx_sr<=i_Reg_Rd_Data, Rd_En high during that bit, go to RD.
  - RD: MISO shifts data. At each close: tx_sr<=i_Reg_Rd_Data of the incremented address, Rd_En high.
  - WR: at each close: Wr_En high during that bit; the bank captures on the close edge.
  - ERR: no strobes; MISO shifts STATUS_ERR repeatedly; o_Frame_Err<=1; exit only on CS high.
- Address increment, applied at the close edge of each WR or RD byte: addr==ADDR_LIMIT → 0, else addr+1.
- tx_sr shifts left, filling with 0, on non-close edges.
- o_Frame_Err survives CS high; cleared only by reset or a valid command close.
- A partial byte at CS rise is discarded: no strobe is issued and the address is not advanced.

## Timing
- Reset values:
  - o_MISO_Bit=0, o_Reg_Addr=0, o_Reg_Wr_En=0, o_Reg_Rd_En=0, o_Reg_Wr_Data=don't-care (strobe gated), o_Busy=0, o_Frame_Err=0.
  - Internal: state=IDLE, count=0, tx_sr=0, rx_sr=0.
- Write latency: 0. The strobe coincides with the last data bit and commits on that edge.
- Read latency: 1 dummy byte. First data appears on MISO the bit after the dummy close edge.
- CS high mid-byte: immediate async return to IDLE; strobes deassert with the state.
- Reset mid-frame: same as CS high, and additionally o_Frame_Err is cleared.

## Configuration
- SPI_SEQ_BURST_EN defined: unlimited auto-increment bursts as described above.
- SPI_SEQ_BURST_EN undefined:
  - One data byte per frame.
  - After the first WR/RD close, go to a DONE state: no strobes, MISO=0, address frozen until CS high.
  - o_Frame_Err is not set by extra bytes.

## Test plan
- Write 0x05 with 0xA7 (frame 0x05,0xA7) → one Wr_En pulse with addr=0x05, data=0xA7 on the 8th data bit; o_Reg_Addr=0x06 after.
- Read 0x10 (frame 0x90,xx,xx), bank[0x10]=0x3C, i_Status=0x81 → MISO 0x00, 0x81, 0x3C; one Rd_En during the dummy byte.
- Burst write at 0x3E with ADDR_LIMIT=0x3F, data 0x11,0x22,0x33 → writes to 0x3E, 0x3F, 0x00.
  - Without SPI_SEQ_BURST_EN: only 0x3E is written.
- Command 0x50 (addr 0x50 > 0x3F) → no strobes, MISO 0xFF per byte, o_Frame_Err=1. Next frame 0x01 clears it at the command close.
- CS high after 4 bits of the second data byte of a write → exactly one Wr_En pulse; state IDLE immediately.
- Assert i_Rst_L low mid-read → all outputs at reset values asynchronously.
